// File: rtl/mem_pkg.sv
// Shared encodings for the byte-addressable data memory.
// Access sizes and the init/run FSM state type.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/load_align.sv
// Load datapath: shift the addressed lane down to bit 0
// and sign- or zero-extend it to the full word width.
module load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] mask;
  logic [6:0]        nbits;
  logic              sgn;

  assign sh = word_i >> {offset_i, 3'b000};

  // Keep the low nbits of the lane, fill the rest with the sign or zero.
  always_comb begin
    nbits = 7'd8;
    unique case (size_i)
      SZ_BYTE:  nbits = 7'd8;
      SZ_HALF:  nbits = 7'd16;
      SZ_WORD:  nbits = 7'd32;
      SZ_DWORD: nbits = 7'd64;
    endcase
    mask   = DATA_W'((65'd1 << nbits) - 65'd1);
    sgn    = ~unsigned_i & (|(sh & (mask ^ (mask >> 1))));
    data_o = (sh & mask) | ({DATA_W{sgn}} & ~mask);
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory with self-clearing init,
// valid/ready request and response channels, one cycle latency.
module byte_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] widx;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic              accept;
  logic              err;
  logic [2:0]        amask;
  logic [7:0]        be8;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] ld_data;

  assign widx   = req_addr >> OFF_W;
  assign idx    = widx[IDX_W-1:0];
  assign off    = req_addr[OFF_W-1:0];
  assign accept = req_valid && req_ready;
  assign wsh    = req_wdata << {off, 3'b000};

  assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // Size decode: alignment mask, lane enables and error checks.
  always_comb begin
    amask = 3'd0;
    be8   = 8'h01;
    unique case (req_size)
      SZ_BYTE:  begin amask = 3'd0; be8 = 8'h01; end
      SZ_HALF:  begin amask = 3'd1; be8 = 8'h03; end
      SZ_WORD:  begin amask = 3'd3; be8 = 8'h0F; end
      SZ_DWORD: begin amask = 3'd7; be8 = 8'hFF; end
    endcase
    be  = NB'(be8) << off;
    err = (|(3'(off) & amask))
        | ((req_size == SZ_DWORD) && (DATA_W == 32))
        | (widx >= ADDR_W'(DEPTH));
  end

  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .word_i     (mem_q[idx]),
    .offset_i   (off),
    .size_i     (req_size),
    .unsigned_i (req_unsigned),
    .data_o     (ld_data)
  );

  // Response payload: loaded data, or zero for stores and errors.
  always_comb begin
    rsp_err_d   = err;
    rsp_rdata_d = (err || req_write) ? '0 : ld_data;
  end

  // Init walks the counter to clear one word per cycle, then runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else if (state_q == ST_INIT) begin
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_q <= ST_RUN;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + IDX_W'(1);
      end
    end
  end

  // Single write port: clearing during init, byte-lane stores in run.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && req_write && !err) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

  // Response register: load on accept, drop on consume, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: directed table,
// backpressure, reset corners and random traffic vs a byte model.
module tb_byte_data_memory;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 32;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  always #5 clk = ~clk;

  byte_data_memory #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned mem_m [DEPTH*NB];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Byte-addressed reference: little-endian bytes, spec error rules.
  function automatic void model(input logic w, input logic [31:0] a,
                                input logic [1:0] sz, input logic u,
                                input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
    longint unsigned n, off, v;
    n   = 64'd1 << sz;
    off = 64'(a) % NB;
    // Bench runs DATA_W=32, so the dword size is always illegal.
    e   = (sz == 2'd3) || (off % n != 0) || (64'(a) / NB >= DEPTH);
    rd  = '0;
    v   = 0;
    if (e) return;
    for (int i = 0; i < int'(n); i++) begin
      if (w) mem_m[int'(a) + i] = wd[8*i +: 8];
      else   v |= longint'(mem_m[int'(a) + i]) << (8*i);
    end
    if (!w) begin
      if (!u && v[8*n-1]) v |= ~((64'd1 << (8*n)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH*NB; i++) mem_m[i] = 8'h00;
  endtask

  // Entered just after a rising edge; returns edges until req_ready.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (cyc >= 400) begin
        chk("ready_timeout", 64'(req_ready), 64'd1);
        break;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  // One request, rsp_ready held high; captures the response.
  task automatic do_access(input logic w, input logic [31:0] a,
                           input logic [1:0] sz, input logic u,
                           input logic [31:0] wd,
                           output logic ok, output logic e,
                           output logic [31:0] rd);
    int cyc;
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    req_wdata    = wd;
    wait_ready(cyc);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    ok = rsp_valid;
    e  = rsp_err;
    rd = rsp_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic run_checked(input string tag, input logic w,
                             input logic [31:0] a, input logic [1:0] sz,
                             input logic u, input logic [31:0] wd);
    logic me, ok, e;
    logic [31:0] mrd, rd;
    model(w, a, sz, u, wd, me, mrd);
    do_access(w, a, sz, u, wd, ok, e, rd);
    chk({tag, "_valid"}, 64'(ok), 64'd1);
    chk({tag, "_err"}, 64'(e), 64'(me));
    chk({tag, "_rdata"}, 64'(rd), 64'(mrd));
  endtask

  initial begin
    int cyc;
    logic ok, e, me;
    logic [31:0] rd, mrd;
    logic [31:0] exp_q [8];

    vt[0]  = '{1'b1, 32'h10,  2'd2, 1'b0, 32'h80FF1234, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h13,  2'd0, 1'b1, 32'h0, 1'b0, 32'h00000080};
    vt[2]  = '{1'b0, 32'h13,  2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFF80};
    vt[3]  = '{1'b0, 32'h10,  2'd1, 1'b0, 32'h0, 1'b0, 32'h00001234};
    vt[4]  = '{1'b1, 32'h20,  2'd2, 1'b0, 32'h11223344, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 32'h21,  2'd0, 1'b0, 32'h000000AB, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 32'h20,  2'd2, 1'b0, 32'h0, 1'b0, 32'h1122AB44};
    vt[7]  = '{1'b0, 32'h11,  2'd1, 1'b0, 32'h0, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 32'h202, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
    vt[9]  = '{1'b0, 32'h10,  2'd3, 1'b0, 32'h0, 1'b1, 32'h0};
    vt[10] = '{1'b1, 32'h20,  2'd3, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
    vt[11] = '{1'b0, 32'h20,  2'd2, 1'b0, 32'h0, 1'b0, 32'h1122AB44};
    vt[12] = '{1'b0, 32'h10,  2'd2, 1'b0, 32'h0, 1'b0, 32'h80FF1234};
    vt[13] = '{1'b0, 32'h12,  2'd1, 1'b1, 32'h0, 1'b0, 32'h000080FF};
    vt[14] = '{1'b0, 32'h12,  2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFF80FF};
    vt[15] = '{1'b1, 32'h200, 2'd2, 1'b0, 32'h55555555, 1'b1, 32'h0};
    vt[16] = '{1'b0, 32'h1FC, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0};

    rst          = 1'b1;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 32'h7C;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    wait_ready(cyc);
    chk("init_ready_cycle", 64'(cyc), 64'd128);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("init_load_valid", 64'(rsp_valid), 64'd1);
    chk("init_load_rdata", 64'(rsp_rdata), 64'h0);
    chk("init_load_err", 64'(rsp_err), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      model(vt[i].w, vt[i].a, vt[i].sz, vt[i].u, vt[i].wd, me, mrd);
      do_access(vt[i].w, vt[i].a, vt[i].sz, vt[i].u, vt[i].wd, ok, e, rd);
      chk($sformatf("vec%0d_valid", i), 64'(ok), 64'd1);
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vt[i].e));
      chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].rd));
    end

    // Backpressure: response must hold, no new accept.
    run_checked("bp_store", 1'b1, 32'h14, 2'd2, 1'b0, 32'h5A5AA5A5);
    rsp_ready    = 1'b0;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 32'h10;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    model(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, me, mrd);
    @(negedge clk);
    chk("bp_first_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_addr = 32'h14;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_ready", k), 64'(req_ready), 64'd0);
      chk($sformatf("bp_hold%0d_valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp_hold%0d_rdata", k), 64'(rsp_rdata), 64'(mrd));
      chk($sformatf("bp_hold%0d_err", k), 64'(rsp_err), 64'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    model(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, me, mrd);
    @(negedge clk);
    chk("bp_release_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 64'(rsp_valid), 64'd1);
    chk("bp_next_rdata", 64'(rsp_rdata), 64'(mrd));
    @(posedge clk);
    #1;

    // Back-to-back loads, one accepted per cycle.
    for (int i = 0; i < 8; i++) begin
      model(1'b0, 32'(4*i + 16), 2'd2, 1'b0, 32'h0, me, mrd);
      exp_q[i] = mrd;
    end
    req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'(4*i + 16);
      @(negedge clk);
      chk($sformatf("b2b%0d_ready", i), 64'(req_ready), 64'd1);
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i), 64'(rsp_valid), 64'd1);
        chk($sformatf("b2b%0d_rdata", i), 64'(rsp_rdata), 64'(exp_q[i-1]));
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_valid", 64'(rsp_valid), 64'd1);
    chk("b2b_last_rdata", 64'(rsp_rdata), 64'(exp_q[7]));
    @(posedge clk);
    #1;

    // Reset with a pending response, then again mid-init.
    run_checked("rs_store", 1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFEF00D);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h40;
    req_size  = 2'd2;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rs_pending_valid", 64'(rsp_valid), 64'd1);
    chk("rs_pending_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async_valid", 64'(rsp_valid), 64'd0);
    chk("rs_async_rdata", 64'(rsp_rdata), 64'd0);
    chk("rs_async_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("rs_midinit_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    wait_ready(cyc);
    chk("rs_reinit_cycle", 64'(cyc), 64'd128);
    @(posedge clk);
    #1;
    run_checked("rs_load40", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
    run_checked("rs_load10", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);

    // Random traffic against the byte model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, DEPTH*NB + 15));
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_checked($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, sz,
                  1'($urandom_range(0, 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 128, meaning number of words; must be a power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: request present.
REQ-007 SHALL have port req_ready, output, 1 bit: request accepted this cycle if req_valid is also high.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-010 SHALL have port req_size, input, 2 bits: access size; 0 = byte, 1 = half, 2 = word32, 3 = dword (DATA_W=64 only).
REQ-011 SHALL have port req_unsigned, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-012 SHALL have port req_wdata, input, DATA_W bits: store data, right-aligned (lane 0).
REQ-013 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-014 SHALL have port rsp_ready, input, 1 bit: response consumed when high together with rsp_valid.
REQ-015 SHALL have port rsp_rdata, output, DATA_W bits: extended load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err, output, 1 bit: misaligned, illegal size, or out-of-range access.

Function
REQ-017 SHALL implement FSM states INIT and RUN.
REQ-018 SHALL, in INIT, write 0 to word counter index each cycle, count 0..DEPTH-1, then enter RUN; req_ready = 0 throughout INIT.
REQ-019 SHALL drive req_ready = (state==RUN) && (!rsp_valid || rsp_ready), giving full throughput of one access per cycle under no backpressure.
REQ-020 SHALL decode accesses as: word index = req_addr >> log2(DATA_W/8); lane offset = low log2(DATA_W/8) address bits.
REQ-021 SHALL flag an error when the lane offset is not a multiple of the access byte count, when size 3 is used with DATA_W=32, or when the word index is at least DEPTH.
REQ-022 SHALL, on an accepted store without error, update only the addressed byte lanes at the accept edge; all other lanes are unchanged.
REQ-023 SHALL, on an accepted load, read the memory state after all earlier accepted stores, shift the lane down, and extend it to DATA_W according to req_unsigned.
REQ-024 SHALL present the response exactly 1 cycle after acceptance (rsp_valid high on the next edge).
REQ-025 SHALL hold rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-026 SHALL, on an error, leave memory unmodified, drive rsp_err=1 and rsp_rdata=0, and still produce the response.
REQ-027 SHALL, when a response is consumed and a new request is accepted in the same cycle, replace the response with the new one with no bubble.
REQ-028 SHALL, when rsp_valid=1 and rsp_ready=0, keep req_ready=0 and accept no new request.

Reset
REQ-029 SHALL, on rst assertion, immediately set state=INIT, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-030 SHALL, on reset during RUN or mid-INIT, discard any pending response and restart INIT from index 0; memory is all-zero DEPTH cycles after rst deasserts.

Structure
REQ-031 SHALL place the size encodings (SZ_BYTE..SZ_DWORD) and the FSM state type in shared package mem_pkg.
REQ-032 SHALL place the load alignment/extension datapath in combinational sub-module load_align (inputs: word, offset, size, unsigned).
REQ-033 SHALL infer a single-port storage array of DEPTH x DATA_W with byte-lane write enables.

Verification
REQ-034 SHALL cover: reset, then 128 cycles with req_valid=1 -> req_ready first rises at cycle 128; load of addr 0x7C -> 0x00000000.
REQ-035 SHALL cover: store word 0x80FF1234 @0x10, then load byte unsigned @0x13 -> 0x00000080; signed @0x13 -> 0xFFFFFF80; half signed @0x10 -> 0x00001234.
REQ-036 SHALL cover: store byte 0xAB @0x21 over word 0x11223344 @0x20 -> load word @0x20 = 0x1122AB44.
REQ-037 SHALL cover: load half @0x11, store word @0x202 (DEPTH=128), and size 3 at DATA_W=32 -> each gives rsp_err=1, rdata=0, memory unchanged.
REQ-038 SHALL cover: rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and response held stable; then back-to-back loads at one per cycle.
REQ-039 SHALL cover: rst pulsed mid-INIT and mid-response -> rsp_valid drops immediately, INIT restarts, and previously stored data reads 0.
